// File: rtl/ir_command_sequencer.sv
// rtl/ir_command_sequencer.sv - bus-written command FIFO that holds each IR car command for N packet slots
module ir_command_sequencer #(
    parameter logic [7:0] BASE_ADDR    = 8'h90,
    parameter int         DEPTH        = 4,
    parameter int         HOLD_PACKETS = 5
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] ADDR_IN,
    input  logic       BUS_WE,
    input  logic [7:0] DATA_IN,
    input  logic       SEND_PACKET,
    output logic [3:0] COMMAND,
    output logic       FIFO_FULL,
    output logic       FIFO_EMPTY,
    output logic [7:0] STATUS
);

    localparam int         PW        = (DEPTH == 4) ? 2 : 1;
    localparam logic [2:0] DEPTH_CNT = 3'(DEPTH);
    localparam logic [3:0] HOLD_DEF  = 4'(HOLD_PACKETS);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t          state, state_n;
    logic [7:0]      mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic [2:0]      count, count_n;
    logic            ovf, ovf_n;
    logic [3:0]      cur_cmd, cur_cmd_n;
    logic [3:0]      cur_hold, cur_hold_n;
    logic [3:0]      pkt_cnt, pkt_cnt_n, pkt_inc;
    logic [3:0]      command_n;
    logic            push_hit, flush, full, empty, pop, do_push;
    logic [7:0]      head;
    logic [3:0]      head_hold;

    assign push_hit  = BUS_WE && (ADDR_IN == BASE_ADDR);
    assign flush     = BUS_WE && (ADDR_IN == BASE_ADDR + 8'd1) && DATA_IN[0];
    assign full      = (count == DEPTH_CNT);
    assign empty     = (count == 3'd0);
    assign head      = mem[rd_ptr];
    assign head_hold = (head[7:4] == 4'd0) ? HOLD_DEF : head[7:4];
    assign pkt_inc   = pkt_cnt + 4'd1;

    assign FIFO_FULL  = full;
    assign FIFO_EMPTY = empty;

    always_comb begin
        state_n    = state;
        pop        = 1'b0;
        cur_cmd_n  = cur_cmd;
        cur_hold_n = cur_hold;
        pkt_cnt_n  = pkt_cnt;
        command_n  = (state == ACTIVE) ? cur_cmd : 4'd0;

        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = ACTIVE;
                end
            end
            ACTIVE: begin
                if (SEND_PACKET) begin
                    pkt_cnt_n = pkt_inc;
                    if (pkt_inc == cur_hold) begin
                        if (!empty) begin
                            pop = 1'b1;
                        end else begin
                            state_n   = IDLE;
                            command_n = 4'd0;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (flush) begin
            state_n   = IDLE;
            pop       = 1'b0;
            command_n = 4'd0;
        end

        if (pop) begin
            cur_cmd_n  = head[3:0];
            cur_hold_n = head_hold;
            pkt_cnt_n  = 4'd0;
        end
    end

    // A pop on the same edge frees the slot a push into a full FIFO needs.
    assign do_push = push_hit && !flush && (!full || pop);

    always_comb begin
        count_n  = count + {2'b00, do_push} - {2'b00, pop};
        wr_ptr_n = do_push ? wr_ptr + 1'b1 : wr_ptr;
        rd_ptr_n = pop ? rd_ptr + 1'b1 : rd_ptr;
        ovf_n    = ovf | (push_hit && full && !pop);
        if (flush) begin
            count_n  = 3'd0;
            wr_ptr_n = '0;
            rd_ptr_n = '0;
            ovf_n    = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= DATA_IN;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= 3'd0;
            ovf      <= 1'b0;
            cur_cmd  <= 4'd0;
            cur_hold <= 4'd0;
            pkt_cnt  <= 4'd0;
            COMMAND  <= 4'd0;
            STATUS   <= 8'h20;
        end else begin
            state    <= state_n;
            wr_ptr   <= wr_ptr_n;
            rd_ptr   <= rd_ptr_n;
            count    <= count_n;
            ovf      <= ovf_n;
            cur_cmd  <= cur_cmd_n;
            cur_hold <= cur_hold_n;
            pkt_cnt  <= pkt_cnt_n;
            COMMAND  <= command_n;
            STATUS   <= {ovf_n, count_n == DEPTH_CNT, count_n == 3'd0,
                         state_n == ACTIVE, 1'b0, count_n};
        end
    end

endmodule

// File: tb/tb_ir_command_sequencer.sv
// tb/tb_ir_command_sequencer.sv - scoreboard bench comparing transmitted commands and status against a queue model
module tb_ir_command_sequencer;

    localparam int DEPTH = 4;
    localparam int HOLD  = 5;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] ADDR_IN = 8'h00;
    logic       BUS_WE = 1'b0;
    logic [7:0] DATA_IN = 8'h00;
    logic       SEND_PACKET = 1'b0;
    logic [3:0] COMMAND;
    logic       FIFO_FULL;
    logic       FIFO_EMPTY;
    logic [7:0] STATUS;

    always #5 CLK = ~CLK;

    ir_command_sequencer #(.BASE_ADDR(8'h90), .DEPTH(DEPTH), .HOLD_PACKETS(HOLD)) dut (
        .CLK(CLK), .RST(RST), .ADDR_IN(ADDR_IN), .BUS_WE(BUS_WE), .DATA_IN(DATA_IN),
        .SEND_PACKET(SEND_PACKET), .COMMAND(COMMAND), .FIFO_FULL(FIFO_FULL),
        .FIFO_EMPTY(FIFO_EMPTY), .STATUS(STATUS)
    );

    int checks = 0;
    int passes = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endfunction

    // Model: the car is either driving a command with some packets left, or stopped.
    logic [7:0] q[$];
    bit         m_active;
    logic [3:0] m_cmd;
    int         m_rem;
    bit         m_ovf;

    logic [3:0] exp_cmd_q[$];
    logic [7:0] exp_stat_q[$];

    function automatic logic [7:0] model_status();
        return {m_ovf, q.size() == DEPTH, q.size() == 0, m_active, 1'b0, 3'(q.size())};
    endfunction

    function automatic void model_reset();
        q.delete();
        m_active = 0;
        m_ovf    = 0;
        m_cmd    = 4'd0;
        m_rem    = 0;
    endfunction

    function automatic void model_load(logic [7:0] e);
        m_active = 1;
        m_cmd    = e[3:0];
        m_rem    = int'(e[7:4]);
    endfunction

    function automatic void model_push(logic [7:0] d);
        logic [3:0] h;
        h = (d[7:4] == 4'd0) ? 4'(HOLD) : d[7:4];
        if (!m_active) model_load({h, d[3:0]});
        else if (q.size() < DEPTH) q.push_back({h, d[3:0]});
        else m_ovf = 1;
    endfunction

    function automatic void model_pulse();
        exp_cmd_q.push_back(m_active ? m_cmd : 4'd0);
        exp_stat_q.push_back(model_status());
        if (m_active) begin
            m_rem--;
            if (m_rem == 0) begin
                if (q.size() > 0) model_load(q.pop_front());
                else m_active = 0;
            end
        end
    endfunction

    always @(negedge CLK) begin
        if (RST && SEND_PACKET) begin
            if (exp_cmd_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                logic [3:0] ec;
                logic [7:0] es;
                ec = exp_cmd_q.pop_front();
                es = exp_stat_q.pop_front();
                check("sb_command", 32'(COMMAND), 32'(ec));
                check("sb_status", 32'(STATUS), 32'(es));
                check("sb_full", 32'(FIFO_FULL), 32'(es[6]));
                check("sb_empty", 32'(FIFO_EMPTY), 32'(es[5]));
            end
        end
    end

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic gap(int n);
        repeat (n) cycle();
    endtask

    task automatic bus_write(logic [7:0] a, logic [7:0] d);
        BUS_WE = 1'b1; ADDR_IN = a; DATA_IN = d;
        if (a == 8'h90) model_push(d);
        else if (a == 8'h91 && d[0]) model_reset();
        cycle();
        BUS_WE = 1'b0;
    endtask

    task automatic pulse();
        SEND_PACKET = 1'b1;
        model_pulse();
        cycle();
        SEND_PACKET = 1'b0;
    endtask

    task automatic pulse_push(logic [7:0] d);
        SEND_PACKET = 1'b1; BUS_WE = 1'b1; ADDR_IN = 8'h90; DATA_IN = d;
        model_pulse();
        model_push(d);
        cycle();
        SEND_PACKET = 1'b0; BUS_WE = 1'b0;
    endtask

    initial begin
        model_reset();
        // Reset held with a live push request: nothing may be queued.
        BUS_WE = 1'b1; ADDR_IN = 8'h90; DATA_IN = 8'h25;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1; BUS_WE = 1'b0;
        check("reset_command", 32'(COMMAND), 32'h0);
        check("reset_status", 32'(STATUS), 32'h20);
        cycle();
        check("reset_empty", 32'(FIFO_EMPTY), 32'h1);
        check("reset_full", 32'(FIFO_FULL), 32'h0);

        // Single command with two-cycle load latency.
        bus_write(8'h90, 8'h25);
        check("load_lat0", 32'(COMMAND), 32'h0);
        cycle();
        check("load_lat1", 32'(COMMAND), 32'h0);
        cycle();
        check("load_lat2", 32'(COMMAND), 32'h5);
        gap(95); pulse();
        gap(99); pulse();
        check("expire_command", 32'(COMMAND), 32'h0);
        check("expire_empty", 32'(FIFO_EMPTY), 32'h1);
        check("expire_active", 32'(STATUS[4]), 32'h0);
        gap(10);

        // Default hold and chaining.
        bus_write(8'h90, 8'h01); gap(3);
        bus_write(8'h90, 8'h32); gap(3);
        check("chain_status", 32'(STATUS), 32'(model_status()));
        repeat (9) begin pulse(); gap(10); end

        // Overflow then flush.
        bus_write(8'h90, 8'h13); gap(3);
        for (int i = 1; i <= 5; i++) begin bus_write(8'h90, 8'(8'h10 + i)); gap(3); end
        check("ovf_full", 32'(FIFO_FULL), 32'h1);
        check("ovf_status", 32'(STATUS), 32'(model_status()));
        repeat (2) begin pulse(); gap(5); end
        bus_write(8'h91, 8'h01);
        check("flush_command", 32'(COMMAND), 32'h0);
        check("flush_status", 32'(STATUS), 32'h20);
        gap(3);
        check("flush_idle", 32'(COMMAND), 32'h0);
        repeat (2) begin pulse(); gap(5); end

        // Full FIFO: push on the same edge as a hold-expiry pop.
        bus_write(8'h90, 8'h17); gap(3);
        for (int i = 1; i <= 4; i++) begin bus_write(8'h90, 8'(8'h10 + i)); gap(3); end
        pulse_push(8'h15); gap(3);
        check("swap_count", 32'(STATUS[2:0]), 32'h4);
        check("swap_status", 32'(STATUS), 32'(model_status()));
        repeat (7) begin pulse(); gap(4); end

        // Reset mid-hold with two entries queued.
        bus_write(8'h90, 8'h36); gap(3);
        bus_write(8'h90, 8'h02); gap(3);
        bus_write(8'h90, 8'h03); gap(3);
        pulse(); gap(3);
        RST = 1'b0;
        model_reset();
        cycle();
        RST = 1'b1;
        check("midreset_command", 32'(COMMAND), 32'h0);
        check("midreset_empty", 32'(FIFO_EMPTY), 32'h1);
        gap(3);
        repeat (3) begin pulse(); gap(4); end

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r < 8)       bus_write(8'h90, {4'($urandom_range(0, 3)), 4'($urandom)});
            else if (r < 17) pulse();
            else if (r == 17) bus_write(8'h91, 8'($urandom_range(0, 1)));
            else             bus_write(8'h92, 8'($urandom));
            gap($urandom_range(3, 8));
        end
        check("final_status", 32'(STATUS), 32'(model_status()));
        check("final_command", 32'(COMMAND), m_active ? 32'(m_cmd) : 32'h0);
        gap(2);
        check("sb_drained", 32'(exp_cmd_q.size()), 32'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
